// File: rtl/seq_unlock_controller.sv
// seq_unlock_controller: multi-step keyed unlock FSM with
// consecutive-fail lockout and idle-timeout abort.
module seq_unlock_controller #(
  parameter int KEY_W = 5,
  parameter int SEQ_LEN = 4,
  parameter logic [SEQ_LEN*KEY_W-1:0] CODE_MASK = 20'h41081,
  parameter logic [SEQ_LEN*KEY_W-1:0] CODE_VAL = 20'h01001,
  parameter int MODE_W = 1,
  parameter int MAX_FAIL = 3,
  parameter int LOCK_CYCLES = 64,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic Clk,
  input  logic Reset_n,
  input  logic [KEY_W-1:0] InputKey,
  input  logic ValidCmd,
  input  logic Logout,
  output logic Active,
  output logic [MODE_W-1:0] Mode,
  output logic Locked,
  output logic [$clog2(MAX_FAIL+1)-1:0] FailCount,
  output logic FailPulse,
  output logic UnlockPulse
);

  localparam int SW = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1;
  localparam int FW = $clog2(MAX_FAIL + 1);
  localparam int LW = $clog2(LOCK_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [SW-1:0] SLAST = SW'(SEQ_LEN - 1);
  localparam logic [FW-1:0] FMAX = FW'(MAX_FAIL);

  typedef enum logic [2:0] {
    IDLE, MATCH, ARMED, ACTIVE, LOCKOUT
  } state_t;

  state_t state_q, state_d;
  logic [SW-1:0] s_q, s_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [LW-1:0] lk_q, lk_d;
  logic act_q, act_d;
  logic [MODE_W-1:0] mode_q, mode_d;
  logic lock_q, lock_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic fp_q, fp_d;
  logic up_q, up_d;

  logic [KEY_W-1:0] cmask, cval;
  logic hit, expire;
  logic [FW-1:0] fnext;
  logic [TW-1:0] tnext;

  always_comb begin
    cmask = '0;
    cval = '0;
    for (int i = 0; i < SEQ_LEN; i++) begin
      if (s_q == SW'(i)) begin
        cmask = CODE_MASK[i*KEY_W +: KEY_W];
        cval = CODE_VAL[i*KEY_W +: KEY_W];
      end
    end
  end

  assign hit = ((InputKey ^ cval) & cmask) == '0;
  assign expire = tmr_q == TW'(TIMEOUT_CYCLES - 1);
  assign tnext = tmr_q + 1'b1;
  assign fnext = (fcnt_q == FMAX) ? fcnt_q : fcnt_q + 1'b1;

  always_comb begin
    state_d = state_q;
    s_d = s_q;
    tmr_d = tmr_q;
    lk_d = lk_q;
    act_d = act_q;
    mode_d = mode_q;
    lock_d = lock_q;
    fcnt_d = fcnt_q;
    fp_d = 1'b0;
    up_d = 1'b0;
    unique case (state_q)
      IDLE, MATCH: begin
        if (Logout) begin
          state_d = IDLE;
          s_d = '0;
          tmr_d = '0;
        end else if (ValidCmd) begin
          tmr_d = '0;
          if (hit && s_q == SLAST) begin
            state_d = ARMED;
            s_d = '0;
          end else if (hit) begin
            state_d = MATCH;
            s_d = s_q + 1'b1;
          end else begin
            fp_d = 1'b1;
            s_d = '0;
            fcnt_d = fnext;
            if (fnext == FMAX) begin
              state_d = LOCKOUT;
              lock_d = 1'b1;
              lk_d = LW'(LOCK_CYCLES);
            end else begin
              state_d = IDLE;
            end
          end
        end else if (state_q == MATCH) begin
          if (expire) begin
            state_d = IDLE;
            s_d = '0;
            tmr_d = '0;
          end else begin
            tmr_d = tnext;
          end
        end
      end
      ARMED: begin
        if (Logout) begin
          state_d = IDLE;
          tmr_d = '0;
        end else if (ValidCmd) begin
          state_d = ACTIVE;
          tmr_d = '0;
          act_d = 1'b1;
          mode_d = InputKey[KEY_W-1 -: MODE_W];
          up_d = 1'b1;
          fcnt_d = '0;
        end else if (expire) begin
          state_d = IDLE;
          tmr_d = '0;
        end else begin
          tmr_d = tnext;
        end
      end
      ACTIVE: begin
        if (Logout) begin
          state_d = IDLE;
          act_d = 1'b0;
          mode_d = '0;
        end else if (ValidCmd) begin
          mode_d = InputKey[KEY_W-1 -: MODE_W];
        end
      end
      LOCKOUT: begin
        if (lk_q == LW'(1)) begin
          state_d = IDLE;
          lock_d = 1'b0;
          fcnt_d = '0;
          lk_d = '0;
        end else begin
          lk_d = lk_q - 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        s_d = '0;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      s_q <= '0;
      tmr_q <= '0;
      lk_q <= '0;
      act_q <= 1'b0;
      mode_q <= '0;
      lock_q <= 1'b0;
      fcnt_q <= '0;
      fp_q <= 1'b0;
      up_q <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q <= s_d;
      tmr_q <= tmr_d;
      lk_q <= lk_d;
      act_q <= act_d;
      mode_q <= mode_d;
      lock_q <= lock_d;
      fcnt_q <= fcnt_d;
      fp_q <= fp_d;
      up_q <= up_d;
    end
  end

  assign Active = act_q;
  assign Mode = mode_q;
  assign Locked = lock_q;
  assign FailCount = fcnt_q;
  assign FailPulse = fp_q;
  assign UnlockPulse = up_q;

endmodule

// File: doc/seq_unlock_controller.md
SEQ_UNLOCK_CONTROLLER -- requirements
Module: seq_unlock_controller

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- KEY_W, 5: key width.
- SEQ_LEN, 4: number of steps in the unlock sequence, range 1..16.
- CODE_MASK, 20'h41081: flattened per-step care mask; step i occupies bits [i*KEY_W +: KEY_W].
- CODE_VAL, 20'h01001: flattened per-step required values, same layout as CODE_MASK.
- MODE_W, 1: mode width, 1..KEY_W.
- MAX_FAIL, 3: consecutive mismatches that trigger lockout, at least 1.
- LOCK_CYCLES, 64: lockout duration in clocks, at least 1.
- TIMEOUT_CYCLES, 256: idle clocks that abort a partial sequence, at least 1.

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- Clk, in, 1: the single clock; all state changes on its rising edge.
- Reset_n, in, 1: reset, asynchronous and active-low.
- InputKey, in, KEY_W: key word.
- ValidCmd, in, 1: qualifies InputKey for one cycle.
- Logout, in, 1: synchronous request to drop the session.
- Active, out, 1: session open.
- Mode, out, MODE_W: current mode.
- Locked, out, 1: lockout in progress.
- FailCount, out, $clog2(MAX_FAIL+1): consecutive mismatches so far.
- FailPulse, out, 1: one-cycle pulse on each mismatch.
- UnlockPulse, out, 1: one-cycle pulse when Active rises.

Function
REQ-003 All outputs SHALL be registered; every response SHALL appear the cycle after the triggering edge.
REQ-004 FSM states SHALL be IDLE, MATCH, ARMED, ACTIVE and LOCKOUT, with step index s ranging 0..SEQ_LEN-1.
REQ-005 Step i SHALL match when (InputKey & mask_i) == (val_i & mask_i).
REQ-006 In IDLE (s=0) or MATCH, a ValidCmd that matches step s SHALL advance s by 1 and enter MATCH; if s=SEQ_LEN-1, it SHALL instead enter ARMED with s=0.
REQ-007 A mismatching ValidCmd in IDLE or MATCH SHALL:
- return the block to IDLE with s=0;
- pulse FailPulse;
- increment FailCount (saturating at MAX_FAIL).
The mismatching key SHALL NOT be re-evaluated as step 0.
REQ-008 When a mismatch makes FailCount reach MAX_FAIL, the block SHALL enter LOCKOUT with Locked=1 and load the lock counter with LOCK_CYCLES.
REQ-009 In LOCKOUT, the lock counter SHALL decrement every cycle and ValidCmd and Logout SHALL be ignored. At count 1 the block SHALL go to IDLE, clear Locked and clear FailCount.
REQ-010 In ARMED, the next ValidCmd SHALL:
- enter ACTIVE and set Active=1;
- set Mode=InputKey[KEY_W-1 -: MODE_W];
- pulse UnlockPulse;
- clear FailCount.
ARMED SHALL perform no match check.
REQ-011 In ACTIVE, each ValidCmd SHALL update Mode from InputKey[KEY_W-1 -: MODE_W]; Active SHALL remain 1.
REQ-012 Logout in IDLE, MATCH, ARMED or ACTIVE SHALL enter IDLE with s=0, Active=0 and Mode=0. FailCount SHALL be unchanged. Logout SHALL take priority over a simultaneous ValidCmd.
REQ-013 The idle timer SHALL count cycles without ValidCmd while in MATCH or ARMED. On reaching TIMEOUT_CYCLES, the block SHALL go to IDLE with s=0 and no fail increment.
REQ-014 The idle timer SHALL clear on any ValidCmd and on each state entry. A ValidCmd in the expiry cycle SHALL win and be processed normally.
REQ-015 SEQ_LEN=1 SHALL go IDLE->ARMED on a single matching command.
REQ-016 UnlockPulse and FailPulse SHALL never be high in the same cycle.

Reset
REQ-017 While Reset_n=0, independent of Clk, the block SHALL force:
- state=IDLE and s=0;
- Active=0, Mode=0, Locked=0;
- FailCount=0, FailPulse=0, UnlockPulse=0;
- both timers to 0.
REQ-018 Reset asserted mid-sequence, mid-lockout or while ACTIVE SHALL abandon all progress. The first edge after release SHALL evaluate from IDLE.

Verification
REQ-019 With default parameters, ValidCmd keys 00001, 00000, 00100, 00000, then 10000 -> UnlockPulse for one cycle, Active=1, Mode=1, FailCount=0.
REQ-020 With Active=1, ValidCmd 00000 -> Mode=0 and Active stays 1; then Logout together with ValidCmd 11111 -> Active=0, Mode=0.
REQ-021 Three ValidCmd 00000 from IDLE -> FailPulse three times, FailCount 1, 2, 3, then Locked=1. During the lockout, a correct sequence has no effect. After 64 cycles, Locked=0 and FailCount=0.
REQ-022 Keys 00001, 00000, then 256 idle cycles -> return to IDLE with FailCount unchanged; a following 00100 is counted as a mismatch.
REQ-023 Reset_n pulsed low while in ARMED and between clock edges -> Active=0 and state=IDLE immediately; a full correct sequence after release unlocks.
REQ-024 Parameters KEY_W=8, SEQ_LEN=6, MODE_W=3 with a random code -> the correct sequence unlocks with Mode=InputKey[7:5]; a single-bit error in any care bit of any step gives a mismatch.
